// File: rtl/aud_pkg.sv
// rtl/aud_pkg.sv - shared constants for the serial audio slave link
// Purpose: audio word and slot sizes, slot indices, and a slot-to-strobe helper.
// Ports: none (package).
package aud_pkg;
   localparam int AUD_DW        = 24;
   localparam int AUD_SLOT_BITS = 32;
   localparam int SLOT0         = 0;
   localparam int SLOT1         = 1;

   // One-hot strobe for a slot index: slot 0 -> 2'b01, slot 1 -> 2'b10.
   function automatic logic [1:0] slot_mask(input logic slot);
      logic [1:0] m;
      m = 2'b00;
      m[slot ? SLOT1 : SLOT0] = 1'b1;
      return m;
   endfunction
endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-stage synchronizer with rise/fall pulses
// Purpose: brings an asynchronous level into the clk domain and flags its edges.
// Ports:
//   clk   in  system clock
//   d     in  asynchronous level
//   rise  out 1-clk pulse when the synced level goes 0 -> 1
//   fall  out 1-clk pulse when the synced level goes 1 -> 0
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic d,
   output logic rise,
   output logic fall
);
   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   // Left unreset on purpose: the chain keeps tracking the pins during reset,
   // so releasing reset never fabricates an edge from a cleared chain.
   always_ff @(posedge clk) begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      prev  <= chain[SYNC_STAGES-1];
   end

   assign rise = chain[SYNC_STAGES-1] & ~prev;
   assign fall = ~chain[SYNC_STAGES-1] & prev;
endmodule

// File: rtl/codec_slave_if.sv
// rtl/codec_slave_if.sv - slave end of a left-justified serial audio link
// Purpose: follows master lrclk/sclk, deserializes s_sdin into words and
//   serializes tx_din0/tx_din1 onto s_sdout. Optional macro:
//   CODEC_SLAVE_FRAME_ERR_EN builds the sticky slot-length check on frame_err.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   s_lrclk, s_sclk     master frame / bit clocks (asynchronous)
//   s_sdin, s_sdout     serial data in (sampled on sclk rise) / out (changes on sclk fall)
//   locked              high after the first lrclk edge since reset
//   rx_vld, rx_data     per-slot receive strobe and received word
//   tx_ack              per-slot strobe when tx_din0/tx_din1 is captured
//   tx_din0, tx_din1    words to send in slot 0 / slot 1
//   frame_err           sticky slot-length error (0 unless the macro is defined)
module codec_slave_if
   import aud_pkg::*;
#(
   parameter int DW          = AUD_DW,
   parameter int SLOT_BITS   = AUD_SLOT_BITS,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s_lrclk,
   input  logic          s_sclk,
   input  logic          s_sdin,
   output logic          s_sdout,
   output logic          locked,
   output logic [1:0]    rx_vld,
   output logic [DW-1:0] rx_data,
   output logic [1:0]    tx_ack,
   input  logic [DW-1:0] tx_din0,
   input  logic [DW-1:0] tx_din1,
   output logic          frame_err
);
   localparam int            CW       = $clog2(SLOT_BITS) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
   localparam logic [CW-1:0] CNT_DW   = CW'(DW);
   localparam logic [CW-1:0] CNT_MAX  = CW'(SLOT_BITS);

   logic                   lr_rise, lr_fall, lr_edge;
   logic                   sck_rise, sck_fall;
   logic [SYNC_STAGES-1:0] sdin_chain;
   logic                   sdin_sync;
   logic                   slot;
   logic [CW-1:0]          bit_cnt;
   logic [DW-1:0]          rx_sr;
   logic [DW-1:0]          tx_sr;
   logic                   rx_done;
   logic                   rx_done_slot;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lrclk_sync (
      .clk  (clk),
      .d    (s_lrclk),
      .rise (lr_rise),
      .fall (lr_fall)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
      .clk  (clk),
      .d    (s_sclk),
      .rise (sck_rise),
      .fall (sck_fall)
   );

   // Same depth as the clock synchronizers so the sampled bit lines up with sck_rise.
   always_ff @(posedge clk) begin
      sdin_chain <= {sdin_chain[SYNC_STAGES-2:0], s_sdin};
   end

   assign sdin_sync = sdin_chain[SYNC_STAGES-1];
   assign lr_edge   = lr_rise | lr_fall;
   assign s_sdout   = tx_sr[DW-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         locked       <= 1'b0;
         slot         <= 1'b0;
         bit_cnt      <= '0;
         rx_sr        <= '0;
         tx_sr        <= '0;
         rx_data      <= '0;
         rx_vld       <= 2'b00;
         tx_ack       <= 2'b00;
         rx_done      <= 1'b0;
         rx_done_slot <= 1'b0;
      end else begin
         rx_vld  <= rx_done ? slot_mask(rx_done_slot) : 2'b00;
         rx_done <= 1'b0;
         tx_ack  <= 2'b00;
         if (lr_edge) begin
            // Frame edge wins over any coincident sclk edge: load MSB, no shift.
            locked  <= 1'b1;
            bit_cnt <= '0;
            slot    <= lr_rise;
            tx_sr   <= lr_rise ? tx_din1 : tx_din0;
            tx_ack  <= slot_mask(lr_rise);
         end else if (locked) begin
            if (sck_rise) begin
               if (bit_cnt < CNT_DW) begin
                  rx_sr <= {rx_sr[DW-2:0], sdin_sync};
               end
               if (bit_cnt == CNT_LAST) begin
                  rx_data      <= {rx_sr[DW-2:0], sdin_sync};
                  rx_done      <= 1'b1;
                  rx_done_slot <= slot;
               end
               if (bit_cnt != CNT_MAX) begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            if (sck_fall) begin
               tx_sr <= {tx_sr[DW-2:0], 1'b0};
            end
         end
      end
   end

`ifdef CODEC_SLAVE_FRAME_ERR_EN
   logic frame_err_q;

   // Flags a slot that ends early/late, or a master sending more than SLOT_BITS clocks.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err_q <= 1'b0;
      end else if (locked &&
                   ((lr_edge && bit_cnt != CNT_MAX) ||
                    (!lr_edge && sck_rise && bit_cnt == CNT_MAX))) begin
         frame_err_q <= 1'b1;
      end
   end

   assign frame_err = frame_err_q;
`else
   assign frame_err = 1'b0;
`endif
endmodule

// File: tb/tb_codec_slave_if.sv
// tb/tb_codec_slave_if.sv - bench for codec_slave_if with a clock-master model
module tb_codec_slave_if;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_lrclk = 1'b1;
   logic        s_sclk = 1'b1;
   logic        s_sdin = 1'b0;
   logic        s_sdout;
   logic        locked;
   logic [1:0]  rx_vld;
   logic [23:0] rx_data;
   logic [1:0]  tx_ack;
   logic [23:0] tx_din0 = 24'h0;
   logic [23:0] tx_din1 = 24'h0;
   logic        frame_err;

   int          vectors = 0;
   int          miscompares = 0;
   logic [25:0] rx_q[$];
   logic [1:0]  ack_q[$];
   logic [25:0] exp_rx;
   logic [1:0]  exp_ack;

`ifdef CODEC_SLAVE_FRAME_ERR_EN
   localparam logic FE_EXP = 1'b1;
`else
   localparam logic FE_EXP = 1'b0;
`endif

   codec_slave_if dut (
      .clk       (clk),
      .rst       (rst),
      .s_lrclk   (s_lrclk),
      .s_sclk    (s_sclk),
      .s_sdin    (s_sdin),
      .s_sdout   (s_sdout),
      .locked    (locked),
      .rx_vld    (rx_vld),
      .rx_data   (rx_data),
      .tx_ack    (tx_ack),
      .tx_din0   (tx_din0),
      .tx_din1   (tx_din1),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every strobe the DUT raises must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && rx_vld != 2'b00) begin
         if (rx_q.size() == 0) begin
            check("rx_vld_unexpected", 32'(rx_vld), 32'h0);
         end else begin
            exp_rx = rx_q.pop_front();
            check("rx_vld", 32'(rx_vld), 32'(exp_rx[25:24]));
            check("rx_data", 32'(rx_data), 32'(exp_rx[23:0]));
         end
      end
      if (!rst && tx_ack != 2'b00) begin
         if (ack_q.size() == 0) begin
            check("tx_ack_unexpected", 32'(tx_ack), 32'h0);
         end else begin
            exp_ack = ack_q.pop_front();
            check("tx_ack", 32'(tx_ack), 32'(exp_ack));
         end
      end
   end

   // Master model for one lrclk half-period: sclk period 8 clk, lrclk changes on
   // the first sclk fall, data MSB first, slave output captured on each sclk rise.
   task automatic run_slot(input logic lvl, input int nbits, input logic [23:0] word,
                           input logic [23:0] txw, input bit exp_rx_en, input bit exp_ack_en,
                           input bit chk_tx, input int rst_bit);
      logic [31:0] cap;
      cap = 32'h0;
      if (lvl) tx_din1 = txw;
      else     tx_din0 = txw;
      if (exp_rx_en)  rx_q.push_back({(lvl ? 2'b10 : 2'b01), word});
      if (exp_ack_en) ack_q.push_back(lvl ? 2'b10 : 2'b01);
      for (int i = 0; i < nbits; i++) begin
         s_sclk  = 1'b0;
         s_lrclk = lvl;
         s_sdin  = (i < 24) ? word[23-i] : 1'($urandom);
         if (i == rst_bit) begin
            rst = 1'b1;
            tick(1);
            check("rst_outputs", {26'h0, locked, rx_vld, tx_ack, s_sdout}, 32'h0);
            check("rst_rx_data", 32'(rx_data), 32'h0);
            check("rst_frame_err", 32'(frame_err), 32'h0);
            tick(2);
            rst = 1'b0;
            tick(1);
         end else begin
            tick(4);
         end
         s_sclk = 1'b1;
         cap[31-i] = s_sdout;
         tick(4);
      end
      if (chk_tx) begin
         check("tx_word", 32'(cap[31:8]), 32'(txw));
         check("tx_pad", 32'(cap[7:0]), 32'h0);
      end
   endtask

   initial begin
      #100_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      tick(4);
      check("reset_outputs", {26'h0, locked, rx_vld, tx_ack, s_sdout}, 32'h0);
      check("reset_frame_err", 32'(frame_err), 32'h0);
      rst = 1'b0;
      tick(2);
      check("locked_pre_edge", 32'(locked), 32'h0);

      // Partial slot with lrclk held high: no edge, so nothing may happen.
      run_slot(1'b1, 8, 24'($urandom), 24'($urandom), 0, 0, 0, -1);
      check("locked_no_edge", 32'(locked), 32'h0);

      run_slot(1'b0, 32, 24'hA5C3F0, 24'h800001, 1, 1, 1, -1);
      check("locked_after_edge", 32'(locked), 32'h1);
      run_slot(1'b1, 32, 24'h0F1E2D, 24'h7FFFFE, 1, 1, 1, -1);

      for (int k = 0; k < 6; k++) begin
         run_slot(k[0], 32, 24'($urandom), 24'($urandom), 1, 1, 1, -1);
      end
      check("frame_err_clean", 32'(frame_err), 32'h0);

      // Short slot: no word, next slot normal.
      run_slot(1'b0, 16, 24'($urandom), 24'($urandom), 0, 1, 0, -1);
      run_slot(1'b1, 32, 24'($urandom), 24'($urandom), 1, 1, 1, -1);
      check("frame_err_short", 32'(frame_err), 32'(FE_EXP));
      run_slot(1'b0, 32, 24'($urandom), 24'($urandom), 1, 1, 1, -1);
      check("frame_err_sticky", 32'(frame_err), 32'(FE_EXP));

      // Reset mid-slot: slot dropped, relock on next edge.
      run_slot(1'b1, 32, 24'($urandom), 24'($urandom), 0, 1, 0, 10);
      check("locked_after_rst", 32'(locked), 32'h0);
      run_slot(1'b0, 32, 24'($urandom), 24'($urandom), 1, 1, 1, -1);
      check("frame_err_post_rst", 32'(frame_err), 32'h0);
      run_slot(1'b1, 32, 24'($urandom), 24'($urandom), 1, 1, 1, -1);
      run_slot(1'b0, 32, 24'($urandom), 24'($urandom), 1, 1, 1, -1);

      s_sclk = 1'b0;
      tick(20);
      check("rx_outstanding", 32'(rx_q.size()), 32'h0);
      check("ack_outstanding", 32'(ack_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
